// File: rtl/serial_transmit.sv
// Byte-wide FIFO feeding a one-bit-per-clock frame serialiser.
// Frame on txd: start 0, eight data bits MSB first, stop 0, then IDLE_BITS ones.
module serial_transmit #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW       = AW + 1;
    localparam int GW       = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
    localparam int GAP_LAST = (IDLE_BITS > 0) ? IDLE_BITS - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          empty;
    logic [7:0]    head;

    state_t        state;
    state_t        state_n;
    logic          txd_n;
    logic          fd_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_n;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_n;
    logic          frame_end;

    assign data_ready = (count < CW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = data_valid && data_ready;
    assign head       = mem[rd_ptr];
    assign busy       = (state != S_IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            txd        <= 1'b1;
            frame_done <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_n;
            txd        <= txd_n;
            frame_done <= fd_n;
            shift      <= shift_n;
            bit_cnt    <= bit_n;
            gap_cnt    <= gap_n;
        end
    end

    always_comb begin
        state_n   = state;
        txd_n     = txd;
        fd_n      = 1'b0;
        shift_n   = shift;
        bit_n     = bit_cnt;
        gap_n     = gap_cnt;
        pop       = 1'b0;
        frame_end = 1'b0;

        unique case (state)
            S_IDLE: begin
                frame_end = 1'b1;
            end
            S_START: begin
                state_n = S_DATA;
                txd_n   = shift[7];
                bit_n   = '0;
            end
            S_DATA: begin
                shift_n = {shift[6:0], 1'b0};
                bit_n   = bit_cnt + 1'b1;
                txd_n   = shift[6];
                if (bit_cnt == 3'd7) begin
                    state_n = S_STOP;
                    txd_n   = 1'b0;
                    fd_n    = 1'b1;
                end
            end
            S_STOP: begin
                if (IDLE_BITS > 0) begin
                    state_n = S_GAP;
                    txd_n   = 1'b1;
                    gap_n   = '0;
                end else begin
                    frame_end = 1'b1;
                end
            end
            S_GAP: begin
                txd_n = 1'b1;
                if (gap_cnt == GW'(GAP_LAST)) begin
                    frame_end = 1'b1;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                txd_n   = 1'b1;
            end
        endcase

        // Any frame boundary either launches the next queued byte or idles.
        if (frame_end) begin
            if (!empty) begin
                pop     = 1'b1;
                shift_n = head;
                txd_n   = 1'b0;
                state_n = S_START;
            end else begin
                state_n = S_IDLE;
                txd_n   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_transmit.sv
// Directed bench for serial_transmit: two instances (IDLE_BITS 1 and 0)
// plus a behavioural one-bit-per-clock receiver on each txd.
module tb_serial_transmit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_a, din_b;
    logic       dv_a, dv_b;
    logic       rdy_a, rdy_b;
    logic       txd_a, txd_b;
    logic       busy_a, busy_b;
    logic       fd_a, fd_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rxq0[$];
    logic [7:0] rxq1[$];
    int         rx_st[2]  = '{0, 0};
    int         rx_cnt[2] = '{0, 0};
    logic [7:0] rx_sh[2];

    always #5 clk = ~clk;

    serial_transmit #(.FIFO_DEPTH(4), .IDLE_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .data_in(din_a), .data_valid(dv_a),
        .data_ready(rdy_a), .txd(txd_a), .busy(busy_a), .frame_done(fd_a)
    );

    serial_transmit #(.FIFO_DEPTH(4), .IDLE_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .data_in(din_b), .data_valid(dv_b),
        .data_ready(rdy_b), .txd(txd_b), .busy(busy_b), .frame_done(fd_b)
    );

    // Receiver: start on a 0, shift 8 bits, stop must be 0 else error word 0x81.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic bt;
            logic [7:0] w;
            bt = (u == 0) ? txd_a : txd_b;
            case (rx_st[u])
                0: if (bt === 1'b0) begin
                    rx_st[u]  = 1;
                    rx_cnt[u] = 0;
                end
                1: begin
                    rx_sh[u] = {rx_sh[u][6:0], bt};
                    rx_cnt[u]++;
                    if (rx_cnt[u] == 8) rx_st[u] = 2;
                end
                default: begin
                    w = (bt === 1'b0) ? rx_sh[u] : 8'h81;
                    if (u == 0) rxq0.push_back(w);
                    else rxq1.push_back(w);
                    rx_st[u] = 0;
                end
            endcase
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        dv_a = 1'b0; dv_b = 1'b0;
        din_a = 8'h00; din_b = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (txd_a !== 1'b1) begin
            n_bad++; $display("FAIL rst_txd: got %b want 1", txd_a);
        end
        n_cmp++;
        if (fd_a !== 1'b0) begin
            n_bad++; $display("FAIL rst_frame_done: got %b want 0", fd_a);
        end
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_bad++; $display("FAIL rst_busy: got %b want 0", busy_a);
        end
        n_cmp++;
        if (rdy_a !== 1'b1) begin
            n_bad++; $display("FAIL rst_ready: got %b want 1", rdy_a);
        end
        n_cmp++;
        if (txd_b !== 1'b1) begin
            n_bad++; $display("FAIL rst_txd_b: got %b want 1", txd_b);
        end
        rxq0.delete();
        rxq1.delete();
    endtask

    task automatic test_single;
        logic [0:10] exp_t;
        logic [0:10] exp_f;
        exp_t = {1'b0, 8'hA5, 1'b0, 1'b1};
        exp_f = {9'b0, 1'b1, 1'b0};
        dv_a = 1'b1; din_a = 8'hA5;
        @(negedge clk);
        dv_a = 1'b0; din_a = 8'h00;
        n_cmp++;
        if (busy_a !== 1'b1 || txd_a !== 1'b1) begin
            n_bad++;
            $display("FAIL single_accept: busy %b txd %b want 1 1", busy_a, txd_a);
        end
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (txd_a !== exp_t[i]) begin
                n_bad++;
                $display("FAIL single_txd[%0d]: got %b want %b", i, txd_a, exp_t[i]);
            end
            n_cmp++;
            if (fd_a !== exp_f[i]) begin
                n_bad++;
                $display("FAIL single_fd[%0d]: got %b want %b", i, fd_a, exp_f[i]);
            end
        end
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_bad++; $display("FAIL single_busy_gap: got %b want 1", busy_a);
        end
        @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_bad++; $display("FAIL single_busy_end: got %b want 0", busy_a);
        end
        n_cmp++;
        if (rxq0.size() != 1 || rxq0[0] !== 8'hA5) begin
            n_bad++;
            $display("FAIL single_rx: got %0d words first %h want 1 word a5",
                     rxq0.size(), (rxq0.size() > 0) ? rxq0[0] : 8'hxx);
        end
        rxq0.delete();
    endtask

    task automatic test_loopback;
        logic [7:0] v[4];
        logic [7:0] g;
        v = '{8'h00, 8'hFF, 8'h81, 8'h5A};
        for (int i = 0; i < 4; i++) begin
            dv_a = 1'b1; din_a = v[i];
            @(negedge clk);
        end
        dv_a = 1'b0;
        repeat (60) @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_bad++; $display("FAIL loop_busy: got %b want 0", busy_a);
        end
        n_cmp++;
        if (rxq0.size() != 4) begin
            n_bad++; $display("FAIL loop_count: got %0d want 4", rxq0.size());
        end
        for (int i = 0; i < 4; i++) begin
            g = (i < rxq0.size()) ? rxq0[i] : 8'hxx;
            n_cmp++;
            if (g !== v[i]) begin
                n_bad++; $display("FAIL loop_word[%0d]: got %h want %h", i, g, v[i]);
            end
        end
        rxq0.delete();
    endtask

    task automatic test_back_to_back;
        logic [0:20] got;
        logic [0:20] exp;
        int nfd;
        exp = {1'b0, 8'h3C, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
        dv_b = 1'b1; din_b = 8'h3C;
        @(negedge clk);
        din_b = 8'hC3;
        @(negedge clk);
        dv_b = 1'b0;
        got[0] = txd_b;
        nfd = int'(fd_b);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            got[i] = txd_b;
            nfd += int'(fd_b);
        end
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("FAIL b2b_line: got %b want %b", got, exp);
        end
        n_cmp++;
        if (nfd != 2) begin
            n_bad++; $display("FAIL b2b_frame_done: got %0d pulses want 2", nfd);
        end
        @(negedge clk);
        n_cmp++;
        if (busy_b !== 1'b0) begin
            n_bad++; $display("FAIL b2b_busy: got %b want 0", busy_b);
        end
        n_cmp++;
        if (rxq1.size() != 2 || rxq1[0] !== 8'h3C || rxq1[1] !== 8'hC3) begin
            n_bad++;
            $display("FAIL b2b_rx: got %0d words want 3c c3", rxq1.size());
        end
        rxq1.delete();
    endtask

    task automatic test_fifo_full;
        int acc;
        int waited;
        logic [7:0] g;
        acc = 0;
        dv_a = 1'b1; din_a = 8'h01;
        for (int c = 0; c < 12 && rdy_a; c++) begin
            @(posedge clk);
            acc++;
            @(negedge clk);
            din_a = din_a + 8'h01;
        end
        n_cmp++;
        if (acc != 5) begin
            n_bad++; $display("FAIL full_accepted: got %0d want 5", acc);
        end
        n_cmp++;
        if (rdy_a !== 1'b0) begin
            n_bad++; $display("FAIL full_ready: got %b want 0", rdy_a);
        end
        din_a = 8'hEE;
        waited = 0;
        while (!rdy_a && waited < 40) begin
            @(negedge clk);
            waited++;
            dv_a = ~dv_a;
        end
        n_cmp++;
        if (waited != 8) begin
            n_bad++; $display("FAIL full_ready_return: got %0d cycles want 8", waited);
        end
        dv_a = 1'b1; din_a = 8'h06;
        @(negedge clk);
        dv_a = 1'b0;
        repeat (70) @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_bad++; $display("FAIL full_busy: got %b want 0", busy_a);
        end
        n_cmp++;
        if (rxq0.size() != 6) begin
            n_bad++; $display("FAIL full_count: got %0d want 6", rxq0.size());
        end
        for (int i = 0; i < 6; i++) begin
            g = (i < rxq0.size()) ? rxq0[i] : 8'hxx;
            n_cmp++;
            if (g !== 8'(i + 1)) begin
                n_bad++; $display("FAIL full_word[%0d]: got %h want %h", i, g, 8'(i + 1));
            end
        end
        rxq0.delete();
    endtask

    task automatic test_reset_mid;
        dv_a = 1'b1; din_a = 8'hF0;
        @(negedge clk);
        din_a = 8'h11;
        @(negedge clk);
        din_a = 8'h22;
        @(negedge clk);
        dv_a = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (txd_a !== 1'b0) begin
            n_bad++; $display("FAIL mid_bit4: got %b want 0", txd_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (txd_a !== 1'b1) begin
            n_bad++; $display("FAIL mid_txd: got %b want 1", txd_a);
        end
        n_cmp++;
        if (busy_a !== 1'b0 || rdy_a !== 1'b1 || fd_a !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_state: busy %b ready %b fd %b want 0 1 0", busy_a, rdy_a, fd_a);
        end
        repeat (15) @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_bad++; $display("FAIL mid_flushed: busy %b want 0", busy_a);
        end
        n_cmp++;
        if (rxq0.size() != 1 || rxq0[0] !== 8'h81) begin
            n_bad++; $display("FAIL mid_err_word: got %0d words want one 81", rxq0.size());
        end
        rxq0.delete();
        dv_a = 1'b1; din_a = 8'h77;
        @(negedge clk);
        dv_a = 1'b0;
        repeat (14) @(negedge clk);
        n_cmp++;
        if (rxq0.size() != 1 || rxq0[0] !== 8'h77) begin
            n_bad++;
            $display("FAIL mid_next: got %0d words first %h want one 77",
                     rxq0.size(), (rxq0.size() > 0) ? rxq0[0] : 8'hxx);
        end
        rxq0.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_loopback();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_transmit.md
Name: serial_transmit

Overview:
- Serial frame transmitter: the sending end of the link decoded by our one-bit-per-clock serial receiver.
- Accepts bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte at one bit per clk cycle as: start bit (0), 8 data bits MSB first, stop bit (0).
- Sits between the byte producer and the txd line. txd connects directly to the receiver's rxd (same clock domain), so loopback tests are direct.

Parameters:
- FIFO_DEPTH, 4, number of byte entries buffered. Power of two, at least 2.
- IDLE_BITS, 1, number of idle '1' cycles forced on txd after every stop bit. 0 means frames go back to back.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset: synchronous, active-high.
- data_in  input  8  byte to send.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  FIFO can accept a byte. Combinational: high when FIFO count < FIFO_DEPTH.
- txd  output  1  serial line, registered. Idle level is 1.
- busy  output  1  FSM not in IDLE, or FIFO not empty.
- frame_done  output  1  one-cycle pulse, registered; high during the cycle txd carries a stop bit.

Behaviour:
- Reset values (after any clk edge with rst=1): txd=1, frame_done=0, busy=0, FIFO empty (data_ready=1), FSM=IDLE, bit counter=0, shift register=0.
- Reset has priority over everything.
- Reset mid-frame: the frame is abandoned, txd returns to 1 on that edge, and buffered bytes are discarded. The downstream receiver then sees 1 at its stop position and flags its error word.
- Handshake: a byte is written when data_valid && data_ready at a clk edge. data_in is sampled on that edge and need not be held afterwards.
- Simultaneous FIFO push and pop in one edge is allowed whenever not full. The count is unchanged.
- data_ready does not look ahead at a same-cycle pop: full means not ready, even if a pop occurs on that edge.
- FIFO ordering is strict first-in first-out. Pointers wrap modulo FIFO_DEPTH. Count is width clog2(FIFO_DEPTH)+1 and never exceeds FIFO_DEPTH or goes below 0.
- FSM states and the txd value driven from the edge entering each state:
  - IDLE: txd=1.
  - START: txd=0.
  - DATA: txd=shift[7].
  - STOP: txd=0, frame_done=1.
  - GAP: txd=1.
- FSM transitions:
  - IDLE -> START when FIFO not empty. On that edge: pop the head into the shift register, set txd=0.
  - START -> DATA after 1 cycle. txd=shift[7], counter=0.
  - DATA: each edge shifts left by one and increments the counter. After 8 DATA cycles (counter reaches 7, then next edge) -> STOP.
  - STOP -> GAP if IDLE_BITS>0. GAP holds txd=1 for exactly IDLE_BITS cycles, then -> START with pop if FIFO not empty, else -> IDLE.
  - STOP -> START directly with pop if IDLE_BITS=0 and FIFO not empty, else -> IDLE.
- Latency: a byte accepted at edge k into an empty FIFO with FSM in IDLE is popped at edge k+1. The start bit is on txd for the cycle after edge k+1.
- Frame length: exactly 10 cycles; period 10+IDLE_BITS cycles.
- frame_done is high exactly one cycle per frame, coincident with the stop bit.
- busy deasserts on the same edge the FSM enters IDLE with the FIFO empty.
- Data bits are never altered. The bit sent in DATA cycle i (i=0..7) is byte[7-i].

Test Plan:
- Single byte 0xA5, IDLE_BITS=1 -> after edge k+1, txd = 0,1,0,1,0,0,1,0,1,0 then 1. frame_done high only in the 10th cycle. busy falls after the GAP cycle.
- Loopback to the receiver, bytes 0x00, 0xFF, 0x81, 0x5A -> receiver word equals each byte in order, one word_on_line pulse per frame, no 0x81 error word except the genuine 0x81 data.
- IDLE_BITS=0, bytes 0x3C and 0xC3 offered on consecutive cycles -> 20 contiguous frame cycles with no 1 between the stop and the next start. Receiver outputs 0x3C then 0xC3.
- FIFO_DEPTH=4, data_valid held high with 0x01, 0x02, ... -> exactly 5 bytes accepted before data_ready drops (1 popped immediately, 4 buffered). data_ready returns the cycle after the next pop. All bytes are transmitted in order; none are lost or duplicated.
- Assert rst for 1 cycle during DATA bit 4 of 0xF0 with 2 bytes queued -> txd=1 from that edge, FIFO empty, busy=0. The receiver produces the 0x81 error word. The next byte 0x77 sent after reset is received correctly.
- data_valid pulsed while data_ready=0 (FIFO full) -> byte not accepted, FIFO contents and count unchanged.
